// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1:N stream demultiplexer.
package demux_pkg;

   // Width of the saturating drop counter.
   localparam int DROP_CNT_W = 8;

   // Occupancy of one output slot.
   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   // Select width: clog2 with a floor of one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: a single-entry register with its valid flag.
// The slot is free when empty or when it drains in the current cycle,
// so a drain and a refill can share one clock edge.
module demux_slot
   import demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             free,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   slot_state_e state;

   assign out_valid = (state == SLOT_FULL);
   assign free      = !out_valid || out_ready;

   // Load wins over drain; a drain without a load empties the slot, data kept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= SLOT_EMPTY;
         out_data <= '0;
      end else if (load) begin
         state    <= SLOT_FULL;
         out_data <= load_data;
      end else if (out_ready) begin
         state    <= SLOT_EMPTY;
      end
   end

endmodule

// File: rtl/demux_1_n_stream.sv
// Registered 1:N stream demultiplexer with per-channel one-entry buffers.
// Unicast goes to the slot picked by in_sel, broadcast waits until every
// slot is free and then loads them all. Out-of-range selects are accepted
// and dropped, flagged by err_sel and counted in drop_cnt.
module demux_1_n_stream
   import demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_OUT = 4,
   parameter int SEL_W = sel_width(N_OUT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WIDTH-1:0]       in_data,
   input  logic [SEL_W-1:0]       in_sel,
   input  logic                   in_bcast,
   output logic [N_OUT-1:0]       out_valid,
   input  logic [N_OUT-1:0]       out_ready,
   output logic [N_OUT*WIDTH-1:0] out_data,
   output logic                   err_sel,
   output logic [DROP_CNT_W-1:0]  drop_cnt
);

   logic [N_OUT-1:0] sel_dec;
   logic [N_OUT-1:0] slot_free;
   logic [N_OUT-1:0] slot_load;
   logic             sel_ok;
   logic             bad_acc;

   // One-hot select decode; all zero when in_sel points past the last channel.
   always_comb begin
      sel_dec = '0;
      for (int k = 0; k < N_OUT; k++)
         if (in_sel == SEL_W'(k)) sel_dec[k] = 1'b1;
   end

   assign sel_ok = |sel_dec;

   // Accept readiness: all slots for broadcast, the target slot for unicast,
   // always for a bad select (the word is simply discarded).
   always_comb begin
      if (in_bcast)     in_ready = &slot_free;
      else if (!sel_ok) in_ready = 1'b1;
      else              in_ready = |(slot_free & sel_dec);
   end

   assign slot_load = {N_OUT{in_valid & in_ready}} & (in_bcast ? {N_OUT{1'b1}} : sel_dec);
   assign bad_acc   = in_valid & ~in_bcast & ~sel_ok;

   genvar g;
   generate
      for (g = 0; g < N_OUT; g++) begin : g_slot
         demux_slot #(.WIDTH(WIDTH)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (slot_load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .free      (slot_free[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*WIDTH +: WIDTH])
         );
      end
   endgenerate

   // Bad-select bookkeeping: one-cycle error pulse and saturating drop count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sel  <= 1'b0;
         drop_cnt <= '0;
      end else begin
         err_sel <= bad_acc;
         if (bad_acc && drop_cnt != {DROP_CNT_W{1'b1}})
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_demux_1_n_stream.sv
// Bench for demux_1_n_stream: directed scenarios on a 4-channel and a
// 3-channel instance, plus a randomized run against a queue scoreboard.
module tb_demux_1_n_stream;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 4-channel instance
   logic        in_valid, in_ready, in_bcast, err_sel;
   logic [7:0]  in_data, drop_cnt;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid, out_ready;
   logic [31:0] out_data;

   // 3-channel instance (select 3 is out of range)
   logic        b_in_valid, b_in_ready, b_in_bcast, b_err_sel;
   logic [7:0]  b_in_data, b_drop_cnt;
   logic [1:0]  b_in_sel;
   logic [2:0]  b_out_valid, b_out_ready;
   logic [23:0] b_out_data;

   int checks = 0;
   int passes = 0;

   demux_1_n_stream #(.WIDTH(8), .N_OUT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .err_sel(err_sel), .drop_cnt(drop_cnt)
   );

   demux_1_n_stream #(.WIDTH(8), .N_OUT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_sel(b_in_sel), .in_bcast(b_in_bcast),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .err_sel(b_err_sel), .drop_cnt(b_drop_cnt)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      in_valid = 0; in_bcast = 0; in_sel = 0; in_data = 0; out_ready = 0;
      b_in_valid = 0; b_in_bcast = 0; b_in_sel = 0; b_in_data = 0; b_out_ready = 0;
   endtask

   task automatic test_reset;
      idle();
      rst_n = 0;
      #12;
      checks++; if (out_valid !== 4'h0) $display("FAIL reset_out_valid got %h want 0", out_valid); else passes++;
      checks++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else passes++;
      checks++; if (err_sel !== 1'b0) $display("FAIL reset_err_sel got %b want 0", err_sel); else passes++;
      checks++; if (drop_cnt !== 8'h0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else passes++;
      checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passes++;
      checks++; if (b_out_valid !== 3'h0) $display("FAIL reset_b_out_valid got %h want 0", b_out_valid); else passes++;
      @(negedge clk) rst_n = 1;
      tick();
   endtask

   task automatic test_unicast_stall;
      in_valid = 1; in_data = 8'hA5; in_sel = 2; out_ready = 4'h0;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL uni_ready_empty got %b want 1", in_ready); else passes++;
      tick();
      in_data = 8'h3C;
      checks++; if (out_valid !== 4'b0100) $display("FAIL uni_valid got %b want 0100", out_valid); else passes++;
      checks++; if (out_data[23:16] !== 8'hA5) $display("FAIL uni_data got %h want a5", out_data[23:16]); else passes++;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL uni_ready_full got %b want 0", in_ready); else passes++;
      tick();
      checks++; if (out_data[23:16] !== 8'hA5 || out_valid !== 4'b0100) $display("FAIL uni_hold got %h/%b want a5/0100", out_data[23:16], out_valid); else passes++;
      out_ready = 4'b0100;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL uni_ready_drain got %b want 1", in_ready); else passes++;
      tick();
      in_valid = 0;
      out_ready = 4'h0;
      checks++; if (out_valid !== 4'b0100 || out_data[23:16] !== 8'h3C) $display("FAIL uni_refill got %h/%b want 3c/0100", out_data[23:16], out_valid); else passes++;
      out_ready = 4'b0100;
      tick();
      out_ready = 4'h0;
      checks++; if (out_valid !== 4'h0 || out_data[23:16] !== 8'h3C) $display("FAIL uni_drained got %h/%b want 3c/0000", out_data[23:16], out_valid); else passes++;
   endtask

   task automatic test_back_to_back;
      out_ready = 4'b0010;
      in_sel = 1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1; in_data = 8'(i);
         #1;
         checks++; if (in_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready); else passes++;
         tick();
         checks++; if (out_valid[1] !== 1'b1 || out_data[15:8] !== 8'(i)) $display("FAIL b2b_data[%0d] got %b/%h want 1/%h", i, out_valid[1], out_data[15:8], 8'(i)); else passes++;
      end
      in_valid = 0;
      tick();
      out_ready = 4'h0;
      checks++; if (out_valid !== 4'h0) $display("FAIL b2b_empty got %b want 0000", out_valid); else passes++;
   endtask

   task automatic test_bcast;
      in_valid = 1; in_sel = 3; in_data = 8'h77; out_ready = 4'h0;
      tick();
      in_bcast = 1; in_sel = 0; in_data = 8'h5A;
      #1;
      checks++; if (in_ready !== 1'b0) $display("FAIL bc_ready_blocked got %b want 0", in_ready); else passes++;
      tick();
      checks++; if (out_valid !== 4'b1000 || out_data[31:24] !== 8'h77) $display("FAIL bc_no_partial got %b/%h want 1000/77", out_valid, out_data[31:24]); else passes++;
      out_ready = 4'b1000;
      #1;
      checks++; if (in_ready !== 1'b1) $display("FAIL bc_ready_drain got %b want 1", in_ready); else passes++;
      tick();
      in_valid = 0; in_bcast = 0; out_ready = 4'h0;
      checks++; if (out_valid !== 4'hF || out_data !== 32'h5A5A5A5A) $display("FAIL bc_all got %b/%h want 1111/5a5a5a5a", out_valid, out_data); else passes++;
      out_ready = 4'hF;
      tick();
      out_ready = 4'h0;
      checks++; if (out_valid !== 4'h0) $display("FAIL bc_drain got %b want 0000", out_valid); else passes++;
   endtask

   task automatic test_bad_sel;
      b_in_valid = 1; b_in_sel = 3; b_in_data = 8'hFF; b_out_ready = 3'h0;
      #1;
      checks++; if (b_in_ready !== 1'b1) $display("FAIL bad_ready got %b want 1", b_in_ready); else passes++;
      tick();
      b_in_valid = 0;
      checks++; if (b_err_sel !== 1'b1) $display("FAIL bad_err_pulse got %b want 1", b_err_sel); else passes++;
      checks++; if (b_drop_cnt !== 8'd1) $display("FAIL bad_drop_one got %0d want 1", b_drop_cnt); else passes++;
      checks++; if (b_out_valid !== 3'h0) $display("FAIL bad_no_load got %b want 000", b_out_valid); else passes++;
      tick();
      checks++; if (b_err_sel !== 1'b0) $display("FAIL bad_err_clear got %b want 0", b_err_sel); else passes++;
      b_in_valid = 1;
      for (int i = 0; i < 300; i++) tick();
      b_in_valid = 0;
      tick();
      checks++; if (b_drop_cnt !== 8'd255) $display("FAIL bad_drop_sat got %0d want 255", b_drop_cnt); else passes++;
      // broadcast ignores the out-of-range select
      b_in_valid = 1; b_in_bcast = 1; b_in_data = 8'h42;
      tick();
      b_in_valid = 0; b_in_bcast = 0;
      checks++; if (b_out_valid !== 3'b111 || b_out_data !== 24'h424242) $display("FAIL bad_bcast got %b/%h want 111/424242", b_out_valid, b_out_data); else passes++;
      checks++; if (b_err_sel !== 1'b0 || b_drop_cnt !== 8'd255) $display("FAIL bad_bcast_err got %b/%0d want 0/255", b_err_sel, b_drop_cnt); else passes++;
   endtask

   task automatic test_random;
      logic [7:0] exp_q [4][$];
      logic [3:0] stalled;
      logic [7:0] held [4];
      logic       exp_rdy;
      int         fails0;
      stalled = 4'h0;
      fails0 = checks - passes;
      for (int c = 0; c < 10000; c++) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (out_valid[k] !== (exp_q[k].size() != 0))
               $display("FAIL rnd_valid ch%0d cyc%0d got %b want %b", k, c, out_valid[k], exp_q[k].size() != 0);
            else if (out_valid[k] && out_data[k*8 +: 8] !== exp_q[k][0])
               $display("FAIL rnd_data ch%0d cyc%0d got %h want %h", k, c, out_data[k*8 +: 8], exp_q[k][0]);
            else if (stalled[k] && (out_valid[k] !== 1'b1 || out_data[k*8 +: 8] !== held[k]))
               $display("FAIL rnd_stable ch%0d cyc%0d got %b/%h want 1/%h", k, c, out_valid[k], out_data[k*8 +: 8], held[k]);
            else passes++;
         end
         if (checks - passes - fails0 > 20) break;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_bcast  = ($urandom_range(0, 4) == 0);
         in_sel    = 2'($urandom_range(0, 3));
         in_data   = 8'($urandom);
         out_ready = 4'($urandom);
         #1;
         if (in_bcast) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < 4; k++)
               if (exp_q[k].size() != 0 && !out_ready[k]) exp_rdy = 1'b0;
         end else begin
            exp_rdy = (exp_q[in_sel].size() == 0) || out_ready[in_sel];
         end
         checks++; if (in_ready !== exp_rdy) $display("FAIL rnd_ready cyc%0d got %b want %b", c, in_ready, exp_rdy); else passes++;
         for (int k = 0; k < 4; k++) begin
            stalled[k] = (exp_q[k].size() != 0) && !out_ready[k];
            held[k]    = (exp_q[k].size() != 0) ? exp_q[k][0] : 8'h00;
            if (exp_q[k].size() != 0 && out_ready[k]) void'(exp_q[k].pop_front());
         end
         if (in_valid && exp_rdy) begin
            for (int k = 0; k < 4; k++)
               if (in_bcast || in_sel == 2'(k)) exp_q[k].push_back(in_data);
         end
         tick();
      end
      // drain what is still held; every queue must empty out
      in_valid = 0; in_bcast = 0; out_ready = 4'hF;
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (out_valid[k] !== (exp_q[k].size() != 0) || (out_valid[k] && out_data[k*8 +: 8] !== exp_q[k][0]))
            $display("FAIL rnd_final ch%0d got %b/%h want %b", k, out_valid[k], out_data[k*8 +: 8], exp_q[k].size() != 0);
         else passes++;
         if (exp_q[k].size() != 0) void'(exp_q[k].pop_front());
      end
      tick();
      out_ready = 4'h0;
      checks++; if (out_valid !== 4'h0) $display("FAIL rnd_drained got %b want 0000", out_valid); else passes++;
   endtask

   task automatic test_reset_mid;
      idle();
      in_valid = 1; in_sel = 0; in_data = 8'h11;
      tick();
      in_sel = 2; in_data = 8'h22;
      tick();
      in_valid = 0; in_sel = 0;
      checks++; if (out_valid !== 4'b0101) $display("FAIL mid_full got %b want 0101", out_valid); else passes++;
      rst_n = 0;
      #1;
      checks++; if (out_valid !== 4'h0 || out_data !== 32'h0) $display("FAIL mid_clear got %b/%h want 0000/0", out_valid, out_data); else passes++;
      checks++; if (b_drop_cnt !== 8'd0 || b_out_valid !== 3'h0) $display("FAIL mid_b_clear got %0d/%b want 0/000", b_drop_cnt, b_out_valid); else passes++;
      @(negedge clk) rst_n = 1;
      tick();
      checks++; if (in_ready !== 1'b1 || out_valid !== 4'h0) $display("FAIL mid_release got %b/%b want 1/0000", in_ready, out_valid); else passes++;
   endtask

   initial begin
      test_reset();
      test_unicast_stall();
      test_back_to_back();
      test_bcast();
      test_bad_sel();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/demux_1_n_stream.md
# demux_1_n_stream

Registered, parametrised 1-to-N stream demultiplexer with a valid/ready handshake on every port. It replaces the single-bit, purely combinational 1:2 demux primitive. A WIDTH-bit word is steered to one of N_OUT output channels, or broadcast to all of them. Each channel holds its word in a one-entry output register until the consumer takes it. The block sits between a single producer and N independent consumers in the gate/datapath fabric.

## Interface
- WIDTH, 8: data word width in bits, minimum 1.
- N_OUT, 4: number of output channels, 2 to 16.
- SEL_W, $clog2(N_OUT): select width. Derived; not to be overridden.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset. Asserts immediately; deassertion is synchronised upstream.
- in_valid  in  1  producer word valid.
- in_ready  out  1  block accepts the word this cycle.
- in_data  in  WIDTH  producer word.
- in_sel  in  SEL_W  target channel index.
- in_bcast  in  1  1 = broadcast to all channels; in_sel is ignored.
- out_valid  out  N_OUT  per-channel word valid.
- out_ready  in  N_OUT  per-channel consumer ready.
- out_data  out  N_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- err_sel  out  1  one-cycle pulse when a word with in_sel >= N_OUT is accepted.
- drop_cnt  out  8  saturating count of words dropped for a bad select.

## Operation
- Input transfer: in_valid & in_ready on a rising clk edge.
- Output transfer on channel k: out_valid[k] & out_ready[k].
- Slot k is free when out_valid[k]=0, or when out_valid[k]=1 and out_ready[k]=1 in the same cycle (drain and refill in one cycle).
- in_ready rules, computed combinationally from the current inputs:
  - Unicast, valid select: in_ready = slot in_sel is free.
  - Broadcast: in_ready = every slot is free. Partial broadcast is never performed.
  - Select >= N_OUT (possible only when N_OUT is not a power of two): in_ready = 1.
- in_ready may depend on in_valid, in_sel, in_bcast and out_ready. The producer must not make in_valid depend on in_ready.
- On an accepted unicast word: slot in_sel loads in_data and its out_valid is set. Other slots are unaffected.
- On an accepted broadcast word: all N_OUT slots load in_data and set out_valid.
- On an accepted bad-select word:
  - The word is discarded and no slot changes.
  - err_sel pulses high for the next cycle.
  - drop_cnt increments, saturating at 255.
- A slot that drains without being refilled clears its out_valid. Its out_data keeps the last value.
- Once out_valid[k]=1, out_data[k] must hold stable until the transfer completes.
- Consumers may deassert out_ready at any time. No combinational path runs from in_* to out_valid or out_data.
- Per-channel state machine: EMPTY/FULL, one bit per channel.
  - EMPTY goes to FULL on a load.
  - FULL goes to EMPTY on a drain without a load.
  - FULL stays FULL on a drain with a load, or on no drain.
- Reset mid-operation: all held words are lost and no handshake completes in the reset cycle.

## Timing
- Latency is 1 cycle: a word accepted at edge t shows on out_valid/out_data after edge t.
- Throughput is one word per cycle per channel when the consumer holds out_ready=1.
- Reset values:
  - out_valid = 0.
  - out_data = 0.
  - err_sel = 0.
  - drop_cnt = 0.
  - in_ready is combinational; with all slots empty it reads 1.
- Simultaneous drain and broadcast into the same slots is legal and loses no data.

## Structure
- Shared package demux_pkg holds:
  - the function for SEL_W, clog2 with a minimum of 1;
  - the localparam DROP_CNT_W = 8;
  - the enum slot_state_e {SLOT_EMPTY, SLOT_FULL}.
- Sub-module demux_slot holds one output register, its valid flag and the free/load/drain logic. It is instantiated N_OUT times in a generate loop.
- The top level holds select decode, in_ready aggregation, error pulse and drop counter.

## Test plan
- Reset, then unicast 0xA5 to ch2 with out_ready=0 on all channels -> out_valid=4'b0100, ch2 data 0xA5. A second word 0x3C to ch2 sees in_ready=0 until out_ready[2]=1.
- Back-to-back unicast 0x01..0x08 to ch1 with out_ready[1]=1 held -> in_ready stays 1, ch1 delivers 0x01..0x08 in order one per cycle, nothing lost.
- Broadcast 0x5A while ch3 is full and stalled -> in_ready=0. Raise out_ready[3] -> broadcast accepted that cycle and all four channels show 0x5A next cycle.
- N_OUT=3, select 3 with data 0xFF -> accepted, no out_valid change, err_sel pulses once, drop_cnt=1. 300 such words -> drop_cnt saturates at 255.
- Random out_ready back-pressure on all channels with a random unicast/broadcast mix over 10k cycles -> scoreboard shows every accepted word delivered exactly once per target, and out_data is stable while stalled.
- Assert rst_n low while ch0 and ch2 are full -> out_valid=0 immediately, drop_cnt=0, in_ready=1 after release.
